// File: rtl/k_cplx_axis_tx_pkg.sv
// Shared definitions for the complex-sample stream: TDATA packing, clog2 helper,
// default component width.
package k_cplx_axis_tx_pkg;

  localparam int unsigned DEF_IN_WIDTH = 16;

  typedef struct packed {
    logic [DEF_IN_WIDTH-1:0] re;
    logic [DEF_IN_WIDTH-1:0] im;
  } cplx_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r = r + 1;
    return r;
  endfunction

  // Real part in the upper half, imaginary in the lower half.
  function automatic logic [2*DEF_IN_WIDTH-1:0] pack_cplx(
    input logic [DEF_IN_WIDTH-1:0] re,
    input logic [DEF_IN_WIDTH-1:0] im
  );
    cplx_t c;
    c.re = re;
    c.im = im;
    return c;
  endfunction

  function automatic cplx_t unpack_cplx(input logic [2*DEF_IN_WIDTH-1:0] d);
    return cplx_t'(d);
  endfunction

endpackage

// File: rtl/k_sync_fifo.sv
// Circular synchronous FIFO with separate count; head entry is read straight
// from the storage registers so the output is show-ahead.
module k_sync_fifo
  import k_cplx_axis_tx_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        wdata,
  input  logic                    pop,
  output logic [WIDTH-1:0]        rdata,
  output logic [clog2(DEPTH):0]   count,
  output logic                    full,
  output logic                    empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage is cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/k_cplx_axis_tx.sv
// AXI4-Stream master for complex samples: buffers upstream strobes in a FIFO,
// packs {re, im} and marks the last beat of each fixed-length frame.
module k_cplx_axis_tx
  import k_cplx_axis_tx_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = DEF_IN_WIDTH,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned FRAME_LEN = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [IN_WIDTH-1:0]     in_re,
  input  logic [IN_WIDTH-1:0]     in_im,
  output logic                    in_ready,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [2*IN_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tlast,
  output logic [clog2(DEPTH):0]   fill_level,
  output logic                    overflow,
  input  logic                    ovf_clr
);

  localparam int unsigned DATA_W = 2 * IN_WIDTH;
  localparam int unsigned BEAT_W = (FRAME_LEN > 1) ? clog2(FRAME_LEN) : 1;

  logic [DATA_W-1:0] wdata;
  logic [BEAT_W-1:0] beat_cnt;
  logic              full;
  logic              empty;
  logic              handshake;

  if (IN_WIDTH == DEF_IN_WIDTH) begin : g_pack_pkg
    assign wdata = pack_cplx(in_re, in_im);
  end else begin : g_pack_cat
    assign wdata = {in_re, in_im};
  end

  assign in_ready      = !full;
  assign m_axis_tvalid = !empty;
  assign handshake     = m_axis_tvalid && m_axis_tready;
  assign m_axis_tlast  = m_axis_tvalid && (beat_cnt == BEAT_W'(FRAME_LEN - 1));

  k_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .wdata (wdata),
    .pop   (handshake),
    .rdata (m_axis_tdata),
    .count (fill_level),
    .full  (full),
    .empty (empty)
  );

  // Frame position of the beat currently at the head of the stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (handshake) begin
      if (beat_cnt == BEAT_W'(FRAME_LEN - 1)) beat_cnt <= '0;
      else                                     beat_cnt <= beat_cnt + BEAT_W'(1);
    end
  end

  // Sticky drop flag; a new drop outranks a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   overflow <= 1'b0;
    else if (in_valid && full) overflow <= 1'b1;
    else if (ovf_clr)          overflow <= 1'b0;
  end

endmodule

// File: tb/tb_k_cplx_axis_tx.sv
// Directed bench for k_cplx_axis_tx with a small queue model of the stream.
module tb_k_cplx_axis_tx;

  localparam int DEPTH     = 4;
  localparam int FRAME_LEN = 8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_re;
  logic [15:0] in_im;
  logic        in_ready;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic [2:0]  fill_level;
  logic        overflow;
  logic        ovf_clr;

  int          n_vec;
  int          n_err;
  logic [31:0] q[$];
  int          beat;
  logic        ovf_m;
  logic        hold_m;
  logic [31:0] hold_data;
  int          nlast;
  int          nbeats;

  k_cplx_axis_tx #(
    .IN_WIDTH  (16),
    .DEPTH     (DEPTH),
    .FRAME_LEN (FRAME_LEN)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_re         (in_re),
    .in_im         (in_im),
    .in_ready      (in_ready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .fill_level    (fill_level),
    .overflow      (overflow),
    .ovf_clr       (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Checks the state left by the previous edge, then drives the next edge and advances the model.
  task automatic step(input logic iv, input logic [15:0] re, input logic [15:0] im,
                      input logic rdy, input logic clr);
    logic full_m;
    logic pop_m;
    @(negedge clk);
    chk("fill_level", 32'(fill_level), 32'(q.size()));
    chk("tvalid", 32'(m_axis_tvalid), 32'(q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
    chk("overflow", 32'(overflow), 32'(ovf_m));
    if (q.size() != 0) begin
      chk("tdata", m_axis_tdata, q[0]);
      chk("tlast", 32'(m_axis_tlast), 32'(beat == FRAME_LEN - 1));
    end
    if (hold_m) chk("tdata_stable", m_axis_tdata, hold_data);
    in_valid      = iv;
    in_re         = re;
    in_im         = im;
    m_axis_tready = rdy;
    ovf_clr       = clr;
    full_m = (q.size() == DEPTH);
    pop_m  = (q.size() != 0) && rdy;
    hold_m = (q.size() != 0) && !rdy;
    hold_data = (q.size() != 0) ? q[0] : 32'h0;
    if (pop_m && m_axis_tlast) nlast++;
    if (iv && full_m) ovf_m = 1'b1;
    else if (clr)     ovf_m = 1'b0;
    if (pop_m) begin
      void'(q.pop_front());
      beat = (beat == FRAME_LEN - 1) ? 0 : beat + 1;
      nbeats++;
    end
    if (iv && !full_m) q.push_back({re, im});
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0; m_axis_tready = 1'b0; ovf_clr = 1'b0;
    in_re = '0; in_im = '0;
    #1;
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_fill", 32'(fill_level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_tdata", m_axis_tdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    beat = 0; ovf_m = 1'b0; hold_m = 1'b0; nlast = 0; nbeats = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int idx;
    logic iv;
    n_vec = 0; n_err = 0;
    rst = 1'b1;
    in_valid = 1'b0; in_re = '0; in_im = '0; m_axis_tready = 1'b0; ovf_clr = 1'b0;
    q.delete(); beat = 0; ovf_m = 1'b0; hold_m = 1'b0; hold_data = '0; nlast = 0; nbeats = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: single sample
    do_reset();
    step(1'b1, 16'h1234, 16'hFFFE, 1'b1, 1'b0);
    settle();
    chk("t1_tvalid", 32'(m_axis_tvalid), 32'd1);
    chk("t1_tdata", m_axis_tdata, 32'h1234FFFE);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("t1_beats", 32'(nbeats), 32'd1);

    // 2: fill against backpressure, drop the fifth, drain, clear overflow
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b1, 16'(16'h0100 + k), 16'(16'hFF00 - k), 1'b0, 1'b0);
    settle();
    chk("t2_in_ready", 32'(in_ready), 32'd0);
    chk("t2_fill", 32'(fill_level), 32'd4);
    step(1'b1, 16'h0104, 16'hFEFC, 1'b0, 1'b0);
    settle();
    chk("t2_overflow", 32'(overflow), 32'd1);
    chk("t2_fill_after_drop", 32'(fill_level), 32'd4);
    chk("t2_head", m_axis_tdata, 32'h0100FF00);
    drain();
    chk("t2_beats", 32'(nbeats), 32'd4);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    settle();
    chk("t2_ovf_clr", 32'(overflow), 32'd0);

    // 3: continuous stream of 20, frame markers on beats 7 and 15
    do_reset();
    for (int k = 0; k < 20; k++) step(1'b1, 16'(k), 16'(16'h8000 + k), 1'b1, 1'b0);
    drain();
    chk("t3_beats", 32'(nbeats), 32'd20);
    chk("t3_nlast", 32'(nlast), 32'd2);
    chk("t3_overflow", 32'(overflow), 32'd0);

    // 4: random backpressure, 100 samples
    do_reset();
    idx = 0;
    for (int c = 0; c < 2000 && (idx < 100 || q.size() != 0); c++) begin
      iv = (idx < 100) && (q.size() != DEPTH) && ($urandom_range(0, 3) != 0);
      step(iv, 16'(idx), 16'(16'hFFFF - idx), 1'($urandom_range(0, 1)), 1'b0);
      if (iv) idx++;
    end
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("t4_beats", 32'(nbeats), 32'd100);
    chk("t4_overflow", 32'(overflow), 32'd0);

    // 5: async reset mid-frame at beat 3 with two buffered
    do_reset();
    step(1'b1, 16'h0A00, 16'h0B00, 1'b0, 1'b0);
    step(1'b1, 16'h0A01, 16'h0B01, 1'b0, 1'b0);
    step(1'b1, 16'h0A02, 16'h0B02, 1'b1, 1'b0);
    step(1'b1, 16'h0A03, 16'h0B03, 1'b1, 1'b0);
    step(1'b1, 16'h0A04, 16'h0B04, 1'b1, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("t5_pre_fill", 32'(fill_level), 32'd2);
    chk("t5_pre_beat", 32'(beat), 32'd3);
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1, 16'(16'h0C00 + k), 16'(16'h0D00 + k), 1'b1, 1'b0);
    drain();
    chk("t5_nlast", 32'(nlast), 32'd1);
    chk("t5_beats", 32'(nbeats), 32'd8);

    // 6: full FIFO with push and pop in the same cycle
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b1, 16'(16'h0E00 + k), 16'(16'h0F00 + k), 1'b0, 1'b0);
    step(1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b0);
    settle();
    chk("t6_fill", 32'(fill_level), 32'd3);
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    chk("t6_overflow", 32'(overflow), 32'd1);
    drain();
    chk("t6_beats", 32'(nbeats), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/k_cplx_axis_tx.md
Name: k_cplx_axis_tx

Overview:
AXI4-Stream master that sends complex samples to stream consumers such as the energy computer.
- Sits at the transmit end of the complex-sample stream. It accepts one-cycle sample strobes from upstream DSP (FFT bins, gain stage, test generator).
- Buffers samples in a small FIFO and packs each into {re, im}.
- Drives m_axis_* with full tvalid/tready backpressure. Asserts tlast on the last beat of each fixed-length frame.

Parameters:
IN_WIDTH, 16, width of each real/imag component (two's complement)
DEPTH, 4, FIFO depth in samples; power of 2, >= 2
FRAME_LEN, 8, beats per frame; tlast on beat FRAME_LEN-1; >= 1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  upstream sample strobe; push when in_valid && in_ready
in_re  input  IN_WIDTH  real component, signed
in_im  input  IN_WIDTH  imaginary component, signed
in_ready  output  1  high when FIFO not full
m_axis_tvalid  output  1  stream data valid
m_axis_tready  input  1  downstream ready
m_axis_tdata  output  2*IN_WIDTH  {re[IN_WIDTH-1:0], im[IN_WIDTH-1:0]}; re in upper half
m_axis_tlast  output  1  last beat of frame
fill_level  output  clog2(DEPTH)+1  samples currently held (0..DEPTH)
overflow  output  1  sticky; set on push attempt while full
ovf_clr  input  1  synchronous clear of overflow

Behaviour:
Reset:
- rst asserted (async) clears FIFO pointers, count, frame counter and overflow.
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, in_ready=1, fill_level=0, overflow=0, m_axis_tdata=0.
- Reset mid-frame discards all buffered samples. The next frame starts at beat 0.

FIFO and output register:
- Circular FIFO of DEPTH entries with wrapping rd/wr pointers and a separate count.
- Output is show-ahead via a registered head: m_axis_tvalid = (count != 0), m_axis_tdata = mem[rd_ptr].

Push, pop and latency:
- Push on a rising edge when in_valid && in_ready. The sample is visible on m_axis one cycle later if the FIFO was empty.
- Pop on a rising edge when m_axis_tvalid && m_axis_tready.
- in_ready = (count != DEPTH), combinational from count only; it does not depend on m_axis_tready.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- When full, push is refused even if a pop happens that cycle. in_ready rises the cycle after the pop.
- in_valid while !in_ready: sample dropped, overflow <= 1. Overflow holds until ovf_clr or rst.
- ovf_clr and a new overflow event in the same cycle: overflow stays 1 (set wins).

AXI-stream rules:
- Once m_axis_tvalid=1, tdata and tlast stay stable until the handshake.
- tvalid never depends combinationally on tready.

Frame counter:
- beat_cnt (0..FRAME_LEN-1) increments on each handshake and wraps to 0 after FRAME_LEN-1.
- m_axis_tlast = m_axis_tvalid && (beat_cnt == FRAME_LEN-1).
- FRAME_LEN=1: tlast on every beat.

Data handling:
- Sign bits of in_re and in_im are passed through unchanged; no arithmetic.
- fill_level = count.

Decomposition:
- Shared package: the TDATA packing function (re upper, im lower) and its inverse, a clog2 helper, and the default IN_WIDTH. The energy computer and this block use the same packing.
- One natural sub-module: k_sync_fifo (parameterised width/depth, push/pop/count/full/empty).
- The top level adds the AXIS adapter, frame counter and overflow flag.

Test Plan:
1. Single sample re=16'h1234, im=16'hFFFE, tready=1: tvalid rises the cycle after push; tdata=32'h1234FFFE; one beat; fill_level returns to 0.
2. tready=0 while pushing 5 samples with DEPTH=4: first 4 accepted, in_ready=0 after 4th, 5th dropped, overflow=1, fill_level=4. Then tready=1: 4 beats out in order, no 5th. ovf_clr clears overflow.
3. Continuous push/pop, FRAME_LEN=8, 20 samples: tlast high on beats 7, 15; beat 19 not last; data order preserved; no overflow.
4. Random tready toggling, 100 samples of incrementing re / decrementing im: tdata stable whenever tvalid && !tready; scoreboard matches all 100 in order.
5. rst pulsed asynchronously mid-frame (beat 3, 2 buffered): tvalid falls immediately, fill_level=0. Next pushed sample gets tlast only at its 8th beat.
6. Full FIFO with push and pop in the same cycle: push refused, count 4->3; in_ready=1 next cycle; overflow set if in_valid was high.
